booth_mult16: RTL and testbench

Multi-cycle radix-2 Booth multiplier for 16-bit signed operands. It sits directly upstream of the existing 16-bit carry-lookahead adder, `cla_adder16`. The multiplier instantiates that adder once and feeds it one add, subtract or pass operation per iteration. The block serves as the MULT unit beside the ALU: a 32-bit product, a 16-bit truncated result and an overflow exception after a fixed latency.

---
 rtl/booth_mult16_pkg.sv | 17 +
 rtl/booth_mult16_cla.sv | 57 +++++
 rtl/booth_mult16.sv | 132 +++++++++++++
 tb/tb_booth_mult16.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/booth_mult16_pkg.sv
// rtl/booth_mult16_pkg.sv - shared types and constants for the Booth multiplier
// Contents: FSM state encoding, datapath width, iteration count.
package booth_mult16_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int MULT_W     = 16;
    localparam int MULT_ITERS = 16;

    // Counter value whose update completes the last Booth iteration.
    localparam logic [4:0] LAST_ITER = 5'(MULT_ITERS - 1);

endpackage

// File: rtl/booth_mult16_cla.sv
// rtl/booth_mult16_cla.sv - 16-bit carry-lookahead adder (cla_adder16)
// Ports:
//   a, b   in  16 : addends
//   c_in   in  1  : carry in
//   sum    out 16 : a + b + c_in (low 16 bits)
//   c_out  out 1  : carry out of bit 15
module cla_adder16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [3:0]  gc;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        // Group generate/propagate for each 4-bit nibble.
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end

        // Second-level lookahead across the four groups.
        gc[0] = c_in;
        gc[1] = gg[0] | (gp[0] & c_in);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_in);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & c_in);
        c_out = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & c_in);

        // Carries inside each group from the group carry-in.
        for (int k = 0; k < 4; k++) begin
            c[4*k]   = gc[k];
            c[4*k+1] = g[4*k]   | (p[4*k]   & gc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])   | (p[4*k+1] & p[4*k] & gc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
        end

        sum = p ^ c;
    end

endmodule

// File: rtl/booth_mult16.sv
// rtl/booth_mult16.sv - multi-cycle radix-2 Booth multiplier, 16x16 signed
// Ports:
//   clock           in  1  : rising-edge clock
//   reset_n         in  1  : asynchronous active-low reset
//   ctrl_start      in  1  : start request (honoured in idle and done states)
//   data_operandA   in  16 : multiplicand, two's complement
//   data_operandB   in  16 : multiplier, two's complement
//   data_product    out 32 : registered full signed product
//   data_result     out 16 : data_product[15:0]
//   data_exception  out 1  : product does not fit in 16 signed bits
//   data_resultRDY  out 1  : one-cycle completion pulse
//   busy            out 1  : operation in flight (run state only)
module booth_mult16
    import booth_mult16_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ctrl_start,
    input  logic [15:0] data_operandA,
    input  logic [15:0] data_operandB,
    output logic [31:0] data_product,
    output logic [15:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    state_t      state_q;
    logic [15:0] m_q;
    logic [16:0] acc_q;
    logic [15:0] q_q;
    logic        qm1_q;
    logic [4:0]  cnt_q;
    logic [31:0] prod_q;
    logic        exc_q;
    logic        rdy_q;
    logic        busy_q;

    logic        op_en;
    logic        op_sub;
    logic [15:0] bop;
    logic [15:0] add_sum;
    logic        add_cout;
    logic [16:0] acc_pre;
    logic [16:0] acc_d;
    logic [15:0] q_d;
    logic        qm1_d;
    logic [31:0] prod_d;
    logic        exc_d;
    logic        load;

    cla_adder16 u_adder (
        .a     (acc_q[15:0]),
        .b     (bop),
        .c_in  (op_sub),
        .sum   (add_sum),
        .c_out (add_cout)
    );

    always_comb begin
        // Booth pair 01 adds M, 10 subtracts M (as ~M + 1), 00/11 pass.
        op_en  = q_q[0] ^ qm1_q;
        op_sub = q_q[0] & ~qm1_q;
        bop    = op_sub ? ~m_q : m_q;

        // Bit 16 extends the 16-bit adder: ACC[16] plus sign of Bop plus carry.
        acc_pre = op_en ? {acc_q[16] ^ bop[15] ^ add_cout, add_sum} : acc_q;

        // Arithmetic right shift of {ACC, Q, q_m1}.
        acc_d = {acc_pre[16], acc_pre[16:1]};
        q_d   = {acc_pre[0], q_q[15:1]};
        qm1_d = q_q[0];

        prod_d = {acc_d[15:0], q_d};
        // Representable iff bits 31..15 are all copies of the sign.
        exc_d  = ~((&prod_d[31:15]) | ~(|prod_d[31:15]));

        load = ctrl_start && (state_q == S_IDLE || state_q == S_DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
            exc_q   <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            if (load) begin
                m_q     <= data_operandA;
                q_q     <= data_operandB;
                acc_q   <= '0;
                qm1_q   <= 1'b0;
                cnt_q   <= '0;
                busy_q  <= 1'b1;
                state_q <= S_RUN;
            end else begin
                case (state_q)
                    S_RUN: begin
                        acc_q <= acc_d;
                        q_q   <= q_d;
                        qm1_q <= qm1_d;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == LAST_ITER) begin
                            // Capture the result on the same edge the last shift lands.
                            prod_q  <= prod_d;
                            exc_q   <= exc_d;
                            rdy_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_DONE;
                        end
                    end
                    S_DONE:  state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign data_product   = prod_q;
    assign data_result    = prod_q[15:0];
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_booth_mult16.sv
// tb/tb_booth_mult16.sv - self-checking bench for booth_mult16
module tb_booth_mult16;

    logic        clock;
    logic        reset_n;
    logic        ctrl_start;
    logic [15:0] data_operandA;
    logic [15:0] data_operandB;
    logic [31:0] data_product;
    logic [15:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    booth_mult16 dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_start     (ctrl_start),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_product   (data_product),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] p;
        logic        e;
    } exp_t;

    exp_t        sb[$];
    int          pass_cnt = 0;
    int          total    = 0;
    logic [31:0] last_p   = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drive a start and record the expected outcome.
    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] p, input logic e);
        exp_t x;
        data_operandA = a;
        data_operandB = b;
        ctrl_start    = 1'b1;
        x.p = p;
        x.e = e;
        sb.push_back(x);
    endtask

    task automatic issue_m(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] pr;
        logic               ov;
        pr = $signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b});
        ov = (pr[31:15] != {17{pr[15]}});
        issue(a, b, pr, ov);
    endtask

    // Waits for RDY (bounded), checks latency and results against the scoreboard.
    // pulse_at > 0 drives a junk start at that cycle, which must be ignored.
    task automatic wait_rdy(input string tag, input int pulse_at);
        int   n;
        bit   seen;
        exp_t x;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clock);
            n++;
            ctrl_start = (n == pulse_at);
            if (n == pulse_at) begin
                data_operandA = 16'h7FFF;
                data_operandB = 16'h1234;
            end
            if (n == 2) chk({tag, "_busy_run"}, 32'(busy), 32'd1);
            if (data_resultRDY === 1'b1) seen = 1'b1;
        end
        x = sb.pop_front();
        if (!seen) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, "_latency"}, 32'(n), 32'd17);
            chk({tag, "_product"}, data_product, x.p);
            chk({tag, "_result"}, 32'(data_result), 32'(x.p[15:0]));
            chk({tag, "_exception"}, 32'(data_exception), 32'(x.e));
            chk({tag, "_busy_done"}, 32'(busy), 32'd0);
            last_p = x.p;
        end
    endtask

    // One cycle after RDY: pulse gone, idle, result held.
    task automatic idle_check(input string tag);
        @(negedge clock);
        chk({tag, "_rdy_pulse"}, 32'(data_resultRDY), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_hold"}, data_product, last_p);
    endtask

    initial begin
        int rdy_seen;
        reset_n       = 1'b0;
        ctrl_start    = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(negedge clock);
        chk("rst_product", data_product, 32'd0);
        chk("rst_result", 32'(data_result), 32'd0);
        chk("rst_exception", 32'(data_exception), 32'd0);
        chk("rst_rdy", 32'(data_resultRDY), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        issue(16'd3, 16'd5, 32'h0000000F, 1'b0);
        wait_rdy("3x5", 0);
        idle_check("3x5");

        @(negedge clock);
        issue(16'hFFF9, 16'd6, 32'hFFFFFFD6, 1'b0);
        wait_rdy("m7x6", 0);
        idle_check("m7x6");

        @(negedge clock);
        issue(16'h8000, 16'hFFFF, 32'h00008000, 1'b1);
        wait_rdy("min_x_m1", 0);
        idle_check("min_x_m1");

        @(negedge clock);
        issue(16'h012C, 16'h012C, 32'h00015F90, 1'b1);
        wait_rdy("300x300", 0);
        idle_check("300x300");

        @(negedge clock);
        issue(16'h8000, 16'h8000, 32'h40000000, 1'b1);
        wait_rdy("min_x_min", 0);
        idle_check("min_x_min");
        repeat (3) @(negedge clock);
        chk("hold_later", data_product, 32'h40000000);

        // Start during run is ignored.
        issue(16'd3, 16'd5, 32'h0000000F, 1'b0);
        wait_rdy("ignore_run", 5);
        idle_check("ignore_run");

        // Start in the done cycle: back-to-back.
        @(negedge clock);
        issue(16'h0123, 16'hFF00, 32'hFFFEDD00, 1'b1);
        wait_rdy("b2b_first", 0);
        issue_m(16'h7FFF, 16'h7FFF);
        wait_rdy("b2b_second", 0);
        idle_check("b2b_second");

        // Asynchronous reset in the middle of iteration 8.
        @(negedge clock);
        data_operandA = 16'h1234;
        data_operandB = 16'h0567;
        ctrl_start    = 1'b1;
        @(negedge clock);
        ctrl_start = 1'b0;
        repeat (8) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_product", data_product, 32'd0);
        chk("arst_result", 32'(data_result), 32'd0);
        chk("arst_exception", 32'(data_exception), 32'd0);
        chk("arst_rdy", 32'(data_resultRDY), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        @(negedge clock);
        reset_n  = 1'b1;
        rdy_seen = 0;
        repeat (25) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) rdy_seen++;
        end
        chk("arst_no_rdy", 32'(rdy_seen), 32'd0);

        issue(16'hFFF9, 16'd6, 32'hFFFFFFD6, 1'b0);
        wait_rdy("post_rst", 0);
        idle_check("post_rst");

        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            issue_m(16'($urandom), 16'($urandom));
            wait_rdy("rand", 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
